ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 20 ++
 rtl/ctrl_seq_if.sv | 26 ++
 rtl/ctrl_seq_timing.sv | 17 +
 rtl/ctrl_seq.sv | 101 ++++++++++
 tb/tb_ctrl_seq.sv | 128 ++++++++++++
 5 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the control sequencer: bus select codes, opcodes,
// the halt encoding and the run/halt state type.
package ctrl_seq_pkg;
   localparam logic [2:0] SEL_AR  = 3'd0;
   localparam logic [2:0] SEL_PC  = 3'd1;
   localparam logic [2:0] SEL_DR  = 3'd2;
   localparam logic [2:0] SEL_AC  = 3'd3;
   localparam logic [2:0] SEL_IR  = 3'd4;
   localparam logic [2:0] SEL_RAM = 3'd6;

   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_REG = 3'd7;

   localparam logic [15:0] HLT_IR = 16'h7001;
   localparam logic [3:0]  SC_MAX = 4'd5;

   typedef enum logic {S_HALT, S_RUN} state_t;
endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer control bus: run/stall inputs and IR towards the sequencer,
// bus select, load/memory strobes and status back to the datapath.
interface ctrl_seq_if #(parameter int N = 16);
   logic         start;
   logic         hold;
   logic [N-1:0] ir;
   logic [2:0]   sss;
   logic         ld_ar, ld_pc, ld_dr, ld_ac, ld_ir;
   logic         inc_pc;
   logic         mem_rd, mem_wr;
   logic [3:0]   sc;
   logic [15:0]  t;
   logic         busy;
   logic         instr_done;

   modport master (
      output start, hold, ir,
      input  sss, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir, inc_pc, mem_rd, mem_wr,
             sc, t, busy, instr_done
   );
   modport slave (
      input  start, hold, ir,
      output sss, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir, inc_pc, mem_rd, mem_wr,
             sc, t, busy, instr_done
   );
endinterface

// File: rtl/ctrl_seq_timing.sv
// Sequence counter with synchronous clear/enable and one-hot T-state decode.
module seq_timing (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   output logic [3:0]  sc,
   output logic [15:0] t
);
   always_ff @(posedge clk) begin
      if (!rst_n)   sc <= 4'd0;
      else if (clr) sc <= 4'd0;
      else if (en)  sc <= sc + 4'd1;
   end

   assign t = 16'd1 << sc;
endmodule

// File: rtl/ctrl_seq.sv
// Basic-computer control sequencer: fetch/indirect/execute micro-steps for
// LDA, STA, BUN and register reference, with stall and halt handling.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int N  = 16,
   parameter int AW = 12
) (
   input logic      clk,
   input logic      rst_n,
   ctrl_seq_if.slave bus
);
   // Address field must sit below the I bit and opcode.
   if (AW < 1 || AW > N - 4) begin : g_bad_aw
      $error("ctrl_seq: AW does not fit below the opcode field");
   end

   state_t     state;
   logic       i_bit;
   logic [2:0] opcode;
   logic       end_instr, bad_sc, run_ok, sc_clr;

   assign bad_sc = bus.sc > SC_MAX;
   assign run_ok = (state == S_RUN) && !bus.hold && !bad_sc;

   always_comb begin
      bus.sss    = SEL_AR;
      bus.ld_ar  = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.ld_dr  = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.inc_pc = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      end_instr  = 1'b0;
      if (run_ok) begin
         case (bus.sc)
            4'd0: begin bus.sss = SEL_PC; bus.ld_ar = 1'b1; end
            4'd1: begin
               bus.sss = SEL_RAM; bus.mem_rd = 1'b1;
               bus.ld_ir = 1'b1; bus.inc_pc = 1'b1;
            end
            4'd2: begin bus.sss = SEL_IR; bus.ld_ar = 1'b1; end
            4'd3: begin
               if (opcode == OP_REG) end_instr = 1'b1;
               else if (i_bit) begin
                  bus.sss = SEL_RAM; bus.mem_rd = 1'b1; bus.ld_ar = 1'b1;
               end
            end
            4'd4: begin
               case (opcode)
                  OP_LDA: begin bus.sss = SEL_RAM; bus.mem_rd = 1'b1; bus.ld_dr = 1'b1; end
                  OP_STA: begin bus.sss = SEL_AC; bus.mem_wr = 1'b1; end_instr = 1'b1; end
                  OP_BUN: begin bus.sss = SEL_AR; bus.ld_pc = 1'b1; end_instr = 1'b1; end
                  default: end_instr = 1'b1;
               endcase
            end
            4'd5: begin
               if (opcode == OP_LDA) begin bus.sss = SEL_DR; bus.ld_ac = 1'b1; end
               end_instr = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.instr_done = end_instr;
   assign bus.busy       = (state == S_RUN);

   // Illegal SC recovery overrides a stall; otherwise hold freezes SC.
   assign sc_clr = (state == S_HALT) || bad_sc || end_instr;

   seq_timing u_timing (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sc_clr),
      .en    (run_ok),
      .sc    (bus.sc),
      .t     (bus.t)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_HALT;
         i_bit  <= 1'b0;
         opcode <= 3'd0;
      end else if (bad_sc) begin
         state <= S_HALT;
      end else if (state == S_HALT) begin
         if (bus.start) state <= S_RUN;
      end else if (!bus.hold) begin
         if (bus.sc == 4'd2) begin
            i_bit  <= bus.ir[N-1];
            opcode <= bus.ir[N-2:N-4];
         end
         if (bus.sc == 4'd3 && opcode == OP_REG && bus.ir == N'(HLT_IR))
            state <= S_HALT;
      end
   end
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: walks LDA direct/indirect, BUN, HLT, stall,
// start+hold in HALT, start while running and reset mid-instruction.
module tb_ctrl_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ctrl_seq_if #(.N(16)) bus ();
   ctrl_seq #(.N(16), .AW(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   // flag order: ar pc dr ac ir inc rd wr busy done
   localparam logic [9:0] F_AR = 10'h200, F_PC = 10'h100, F_DR = 10'h080,
                          F_AC = 10'h040, F_IR = 10'h020, F_INC = 10'h010,
                          F_RD = 10'h008, F_WR = 10'h004, F_BSY = 10'h002,
                          F_DN = 10'h001;

   function automatic logic [12:0] mk(input logic [2:0] s, input logic [9:0] f);
      return {s, f};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] esc, input logic [12:0] ev);
      logic [12:0] ov;
      logic [15:0] et;
      #1;
      ov = {bus.sss, bus.ld_ar, bus.ld_pc, bus.ld_dr, bus.ld_ac, bus.ld_ir,
            bus.inc_pc, bus.mem_rd, bus.mem_wr, bus.busy, bus.instr_done};
      et = 16'd1 << esc;
      checks++;
      assert (ov === ev) else begin
         errors++;
         $error("FAIL %s outputs got %h expected %h", tag, ov, ev);
      end
      checks++;
      assert (bus.sc === esc) else begin
         errors++;
         $error("FAIL %s sc got %0d expected %0d", tag, bus.sc, esc);
      end
      checks++;
      assert (bus.t === et) else begin
         errors++;
         $error("FAIL %s t got %h expected %h", tag, bus.t, et);
      end
   endtask

   initial begin
      rst_n = 1'b0; bus.start = 1'b0; bus.hold = 1'b0; bus.ir = 16'h2123;
      tick; tick;
      rst_n = 1'b1;
      chk("reset", 4'd0, mk(3'd0, 10'h0));
      tick;
      chk("idle", 4'd0, mk(3'd0, 10'h0));

      // LDA direct
      bus.start = 1'b1; tick; bus.start = 1'b0;
      chk("lda_t0", 4'd0, mk(3'd1, F_AR | F_BSY));
      tick; chk("lda_t1", 4'd1, mk(3'd6, F_IR | F_INC | F_RD | F_BSY));
      tick; chk("lda_t2", 4'd2, mk(3'd4, F_AR | F_BSY));
      tick; chk("lda_t3", 4'd3, mk(3'd0, F_BSY));
      tick; chk("lda_t4", 4'd4, mk(3'd6, F_DR | F_RD | F_BSY));
      tick; chk("lda_t5", 4'd5, mk(3'd2, F_AC | F_BSY | F_DN));
      tick; chk("lda_wrap", 4'd0, mk(3'd1, F_AR | F_BSY));

      // LDA indirect
      bus.ir = 16'hA050;
      tick; chk("ind_t1", 4'd1, mk(3'd6, F_IR | F_INC | F_RD | F_BSY));
      tick; chk("ind_t2", 4'd2, mk(3'd4, F_AR | F_BSY));
      tick; chk("ind_t3", 4'd3, mk(3'd6, F_AR | F_RD | F_BSY));
      tick; chk("ind_t4", 4'd4, mk(3'd6, F_DR | F_RD | F_BSY));
      tick; chk("ind_t5", 4'd5, mk(3'd2, F_AC | F_BSY | F_DN));
      tick; chk("ind_wrap", 4'd0, mk(3'd1, F_AR | F_BSY));

      // BUN
      bus.ir = 16'h4077;
      tick; tick;
      tick; chk("bun_t3", 4'd3, mk(3'd0, F_BSY));
      tick; chk("bun_t4", 4'd4, mk(3'd0, F_PC | F_BSY | F_DN));
      tick; chk("bun_next", 4'd0, mk(3'd1, F_AR | F_BSY));

      // HLT with a 3-cycle stall at T1
      bus.ir = 16'h7001;
      tick;
      bus.hold = 1'b1;
      chk("hold_a", 4'd1, mk(3'd0, F_BSY));
      tick; chk("hold_b", 4'd1, mk(3'd0, F_BSY));
      tick; chk("hold_c", 4'd1, mk(3'd0, F_BSY));
      tick;
      bus.hold = 1'b0;
      chk("hold_rel", 4'd1, mk(3'd6, F_IR | F_INC | F_RD | F_BSY));
      tick; chk("hlt_t2", 4'd2, mk(3'd4, F_AR | F_BSY));
      tick; chk("hlt_t3", 4'd3, mk(3'd0, F_BSY | F_DN));
      tick; chk("halted", 4'd0, mk(3'd0, 10'h0));
      tick; chk("halted2", 4'd0, mk(3'd0, 10'h0));

      // start and hold together in HALT, then STA interrupted by reset at T4
      bus.ir = 16'h3055;
      bus.start = 1'b1; bus.hold = 1'b1;
      tick; bus.start = 1'b0;
      chk("sh_run", 4'd0, mk(3'd0, F_BSY));
      tick; chk("sh_held", 4'd0, mk(3'd0, F_BSY));
      bus.hold = 1'b0;
      chk("sh_t0", 4'd0, mk(3'd1, F_AR | F_BSY));
      tick;
      bus.start = 1'b1;
      chk("sta_t1", 4'd1, mk(3'd6, F_IR | F_INC | F_RD | F_BSY));
      tick; bus.start = 1'b0;
      chk("start_ign", 4'd2, mk(3'd4, F_AR | F_BSY));
      tick; tick;
      chk("sta_t4", 4'd4, mk(3'd3, F_WR | F_BSY | F_DN));
      rst_n = 1'b0; bus.start = 1'b1; bus.hold = 1'b1;
      tick;
      chk("rst_t4", 4'd0, mk(3'd0, 10'h0));
      tick;
      chk("rst_prio", 4'd0, mk(3'd0, 10'h0));
      rst_n = 1'b1; bus.start = 1'b0; bus.hold = 1'b0;
      tick; chk("post_rst", 4'd0, mk(3'd0, 10'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
